// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings and digit limits for the time edit controller
package clock_pkg;
  typedef enum logic [1:0] {RUN, SNAP, EDIT, COMMIT} state_t;
  localparam logic [1:0] DIG_HRL = 2'd0;
  localparam logic [1:0] DIG_HRR = 2'd1;
  localparam logic [1:0] DIG_ML  = 2'd2;
  localparam logic [1:0] DIG_MR  = 2'd3;
  localparam logic [3:0] MAX_HRL    = 4'd2;
  localparam logic [3:0] MAX_HRR    = 4'd9;
  localparam logic [3:0] MAX_HRR_20 = 4'd3;
  localparam logic [3:0] MAX_ML     = 4'd5;
  localparam logic [3:0] MAX_MR     = 4'd9;
endpackage

// File: rtl/digit_step.sv
// digit_step: wrap-around increment/decrement of one BCD digit within 0..max
module digit_step (
  input  logic [3:0] i_val,
  input  logic [3:0] i_max,
  input  logic       i_up,
  input  logic       i_down,
  output logic [3:0] o_val
);
  always_comb begin
    o_val = i_up   ? ((i_val >= i_max) ? 4'd0 : i_val + 4'd1) :
            i_down ? ((i_val == 4'd0) ? i_max : i_val - 4'd1) : i_val;
  end
endmodule

// File: rtl/time_edit_ctrl.sv
// time_edit_ctrl: freezes the time counter, edits a shadow HH:MM, commits it back with a load strobe
module time_edit_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit_sw,
  input  logic       bU,
  input  logic       bD,
  input  logic       bL,
  input  logic       bR,
  input  logic       bC,
  input  logic [1:0] cur_hrL,
  input  logic [3:0] cur_hrR,
  input  logic [2:0] cur_mL,
  input  logic [3:0] cur_mR,
  output logic       run_en,
  output logic       load,
  output logic [1:0] ld_hrL,
  output logic [3:0] ld_hrR,
  output logic [2:0] ld_mL,
  output logic [3:0] ld_mR,
  output logic [1:0] sel,
  output logic       editing,
  output logic       blink
);
  localparam int CW = $clog2(BLINK_DIV);

  state_t          r_state;
  state_t          w_next;
  logic            r_sw_q;
  logic [1:0]      r_hrl;
  logic [3:0]      r_hrr;
  logic [2:0]      r_ml;
  logic [3:0]      r_mr;
  logic [1:0]      r_sel;
  logic [CW-1:0]   r_cnt;
  logic            r_blink;
  logic            w_rise, w_fall, w_commit, w_edit;
  logic            w_left, w_right, w_up, w_down, w_act;
  logic [3:0]      w_cur, w_max, w_step;

  assign w_rise   = edit_sw & ~r_sw_q;
  assign w_fall   = ~edit_sw & r_sw_q;
  assign w_commit = bC | w_fall;
  assign w_edit   = (r_state == EDIT) & ~w_commit;
  // Commit beats digit buttons; among them only the highest-priority one acts.
  assign w_left   = w_edit & bL;
  assign w_right  = w_edit & ~bL & bR;
  assign w_up     = w_edit & ~bL & ~bR & bU;
  assign w_down   = w_edit & ~bL & ~bR & ~bU & bD;
  assign w_act    = w_left | w_right | w_up | w_down;

  always_comb begin
    w_next = (r_state == RUN)  ? (w_rise ? SNAP : RUN) :
             (r_state == SNAP) ? EDIT :
             (r_state == EDIT) ? (w_commit ? COMMIT : EDIT) : RUN;
  end

  always_comb begin
    w_cur = (r_sel == DIG_HRL) ? {2'b00, r_hrl} :
            (r_sel == DIG_HRR) ? r_hrr :
            (r_sel == DIG_ML)  ? {1'b0, r_ml} : r_mr;
    w_max = (r_sel == DIG_HRL) ? MAX_HRL :
            (r_sel == DIG_HRR) ? ((r_hrl == 2'd2) ? MAX_HRR_20 : MAX_HRR) :
            (r_sel == DIG_ML)  ? MAX_ML : MAX_MR;
  end

  digit_step u_step (
    .i_val (w_cur),
    .i_max (w_max),
    .i_up  (w_up),
    .i_down(w_down),
    .o_val (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_sw_q  <= 1'b0;
      r_hrl   <= '0;
      r_hrr   <= '0;
      r_ml    <= '0;
      r_mr    <= '0;
      r_sel   <= DIG_HRL;
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sw_q  <= edit_sw;
      if (r_state == SNAP) begin
        r_hrl   <= cur_hrL;
        r_hrr   <= cur_hrR;
        r_ml    <= cur_mL;
        r_mr    <= cur_mR;
        r_sel   <= DIG_HRL;
        r_cnt   <= '0;
        r_blink <= 1'b0;
      end else if (w_edit) begin
        if (w_act) begin
          r_cnt   <= '0;
          r_blink <= 1'b0;
        end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
          r_cnt   <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_left) r_sel <= r_sel - 2'd1;
        if (w_right) r_sel <= r_sel + 2'd1;
        if ((w_up | w_down) && r_sel == DIG_HRL) begin
          r_hrl <= w_step[1:0];
          // Entering the 20s must pull hours units into 0..3 in the same cycle.
          if (w_step == 4'd2 && r_hrr > MAX_HRR_20) r_hrr <= MAX_HRR_20;
        end
        if ((w_up | w_down) && r_sel == DIG_HRR) r_hrr <= w_step;
        if ((w_up | w_down) && r_sel == DIG_ML) r_ml <= w_step[2:0];
        if ((w_up | w_down) && r_sel == DIG_MR) r_mr <= w_step;
      end
    end
  end

  assign run_en  = (r_state == RUN);
  assign load    = (r_state == COMMIT);
  assign editing = (r_state != RUN);
  assign blink   = r_blink & (r_state == EDIT);
  assign ld_hrL  = r_hrl;
  assign ld_hrR  = r_hrr;
  assign ld_mL   = r_ml;
  assign ld_mR   = r_mr;
  assign sel     = r_sel;
endmodule
